cpu_exec_core: RTL and testbench

Execution core of the 16-bit accumulator CPU. It holds the AC and E registers, computes next-state values for AC/E from one-hot micro-operation strobes (ALU), drives the shared 16-bit bus from an 8-way source select, and decodes the sequence counter and opcode field into one-hot timing (`t`) and opcode (`d`) vectors. The control unit sits around it and consumes `t`/`d`/`bus_data`. Memory, AR, PC, DR, IR and the sequencer stay outside.

---
 rtl/cpu_ex3_pkg.sv | 26 ++
 rtl/cpu_exec_core_if.sv | 31 +++
 rtl/cpu_exec_core_dec.sv | 25 ++
 rtl/cpu_exec_core.sv | 177 +++++++++++++++++
 tb/tb_cpu_exec_core.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ex3_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ex3_pkg
// Shared definitions for the accumulator CPU execution core: datapath widths,
// bus source select encoding and the default program entry point.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_ex3_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;

  // Source select encoding for the shared 16-bit bus
  typedef enum logic [2:0] {
    BUS_ENTRY = 3'd0,
    BUS_AR    = 3'd1,
    BUS_PC    = 3'd2,
    BUS_DR    = 3'd3,
    BUS_AC    = 3'd4,
    BUS_IR    = 3'd5,
    BUS_ZERO  = 3'd6,
    BUS_MEM   = 3'd7
  } bus_sel_e;

  localparam logic [DATA_W-1:0] ENTRY_POINT_DEF = 16'h0000;

endpackage : cpu_ex3_pkg

// File: rtl/cpu_exec_core_if.sv
// -----------------------------------------------------------------------------
// cpu_exec_core_if
// Shared-bus bundle between the control unit and the execution core: the bus
// sources held outside the core (AR, PC, DR, IR, memory data, input char),
// the source select and the resulting bus value.
//   master : control unit side - drives sources and select, reads bus_data
//   slave  : execution core side - reads sources and select, drives bus_data
// -----------------------------------------------------------------------------
interface cpu_exec_core_if;
  import cpu_ex3_pkg::*;

  logic [2:0]        bus_ctl;
  logic [ADDR_W-1:0] ar;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mem_data;
  logic [7:0]        inpr;
  logic [DATA_W-1:0] bus_data;

  modport master (
    output bus_ctl, ar, pc, dr, ir, mem_data, inpr,
    input  bus_data
  );

  modport slave (
    input  bus_ctl, ar, pc, dr, ir, mem_data, inpr,
    output bus_data
  );

endinterface : cpu_exec_core_if

// File: rtl/cpu_exec_core_dec.sv
// -----------------------------------------------------------------------------
// exec_dec_3to8
// 3-to-8 one-hot decoder with enable. Used for the timing (sequence counter)
// and opcode decodes of the execution core.
//   en  in  1 : decode enable; 0 forces all outputs low
//   sel in  3 : value to decode
//   y   out 8 : one-hot result, y[k] = en && (sel == k)
// -----------------------------------------------------------------------------
module exec_dec_3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // One-hot decode of sel, gated by en
  always_comb begin
    y = 8'h00;
    if (en) begin
      y = 8'h01 << sel;
    end else begin
      y = 8'h00;
    end
  end

endmodule : exec_dec_3to8

// File: rtl/cpu_exec_core.sv
// -----------------------------------------------------------------------------
// cpu_exec_core
// Execution core of the 16-bit accumulator CPU: AC and E registers, the ALU
// producing next AC/E values from one-hot micro-op strobes, the 8-way shared
// bus mux, and one-hot decodes of the sequence counter (t) and opcode (d).
//
// Ports:
//   clk, rst_n            : rising-edge clock, async active-low reset
//   en                    : register update enable (0 freezes AC/E)
//   bus_if (slave)        : bus sources, bus_ctl select, bus_data result
//   sc                    : sequence counter, decoded to t
//   ac_and..ac_shl        : AC load strobes (priority as listed in the ALU)
//   ac_inr, ac_clr        : AC increment / clear
//   e_clr, e_cmp          : E clear / complement
//   ac, e                 : registered state
//   ac_nxt, e_nxt         : combinational ALU results
//   t, d                  : one-hot decodes of sc and ir[14:12]
//
// Build option: define EXEC_INC_CARRY_EN to make an ac_inr update also load E
// with the carry out of ac + 1.
// -----------------------------------------------------------------------------
module cpu_exec_core
  import cpu_ex3_pkg::*;
#(
  parameter logic [DATA_W-1:0] ENTRY_POINT = ENTRY_POINT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  cpu_exec_core_if.slave    bus_if,
  input  logic [2:0]        sc,
  input  logic              ac_and,
  input  logic              ac_add,
  input  logic              ac_dr,
  input  logic              ac_inpr,
  input  logic              ac_cmp,
  input  logic              ac_shr,
  input  logic              ac_shl,
  input  logic              ac_inr,
  input  logic              ac_clr,
  input  logic              e_clr,
  input  logic              e_cmp,
  output logic [DATA_W-1:0] ac,
  output logic              e,
  output logic [DATA_W-1:0] ac_nxt,
  output logic              e_nxt,
  output logic [7:0]        t,
  output logic [7:0]        d
);

  logic [DATA_W-1:0] ac_q, ac_d;
  logic              e_q, e_d;
  logic [DATA_W:0]   sum_s;
  logic              ac_ld_s;

  assign ac = ac_q;
  assign e  = e_q;

  // 17-bit sum keeps the carry for E on ac_add
  assign sum_s   = {1'b0, ac_q} + {1'b0, bus_if.dr};
  assign ac_ld_s = ac_and | ac_add | ac_dr | ac_inpr | ac_cmp | ac_shr | ac_shl;

  // ALU: AC next value, first active load strobe wins
  always_comb begin
    ac_nxt = ac_q;
    if (ac_and) begin
      ac_nxt = ac_q & bus_if.dr;
    end else if (ac_add) begin
      ac_nxt = sum_s[DATA_W-1:0];
    end else if (ac_dr) begin
      ac_nxt = bus_if.dr;
    end else if (ac_inpr) begin
      ac_nxt = {ac_q[15:8], bus_if.inpr};
    end else if (ac_cmp) begin
      ac_nxt = ~ac_q;
    end else if (ac_shr) begin
      ac_nxt = {e_q, ac_q[15:1]};
    end else if (ac_shl) begin
      ac_nxt = {ac_q[14:0], e_q};
    end else begin
      ac_nxt = ac_q;
    end
  end

  // ALU: E next value, first matching condition wins
  always_comb begin
    e_nxt = e_q;
    if (ac_add) begin
      e_nxt = sum_s[DATA_W];
    end else if (ac_shr) begin
      e_nxt = ac_q[0];
    end else if (ac_shl) begin
      e_nxt = ac_q[15];
    end else if (e_clr) begin
      e_nxt = 1'b0;
    end else if (e_cmp) begin
      e_nxt = ~e_q;
    end else begin
      e_nxt = e_q;
    end
  end

  // Next-state for AC: clear beats load beats increment
  always_comb begin
    ac_d = ac_q;
    if (!en) begin
      ac_d = ac_q;
    end else if (ac_clr) begin
      ac_d = 16'h0000;
    end else if (ac_ld_s) begin
      ac_d = ac_nxt;
    end else if (ac_inr) begin
      ac_d = ac_q + 16'h0001;
    end else begin
      ac_d = ac_q;
    end
  end

  // Next-state for E: follows e_nxt on every enabled cycle
  always_comb begin
    e_d = e_q;
    if (!en) begin
      e_d = e_q;
    end else begin
`ifdef EXEC_INC_CARRY_EN
      // Increment carry out is set only when ac rolls over from all-ones
      if (ac_inr && !ac_clr && !ac_ld_s) begin
        e_d = &ac_q;
      end else begin
        e_d = e_nxt;
      end
`else
      e_d = e_nxt;
`endif
    end
  end

  // AC/E state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q <= 16'h0000;
      e_q  <= 1'b0;
    end else begin
      ac_q <= ac_d;
      e_q  <= e_d;
    end
  end

  // Shared bus source mux
  always_comb begin
    bus_if.bus_data = 16'h0000;
    case (bus_sel_e'(bus_if.bus_ctl))
      BUS_ENTRY: bus_if.bus_data = ENTRY_POINT;
      BUS_AR:    bus_if.bus_data = {4'h0, bus_if.ar};
      BUS_PC:    bus_if.bus_data = {4'h0, bus_if.pc};
      BUS_DR:    bus_if.bus_data = bus_if.dr;
      BUS_AC:    bus_if.bus_data = ac_q;
      BUS_IR:    bus_if.bus_data = bus_if.ir;
      BUS_ZERO:  bus_if.bus_data = 16'h0000;
      BUS_MEM:   bus_if.bus_data = bus_if.mem_data;
      default:   bus_if.bus_data = 16'h0000;
    endcase
  end

  exec_dec_3to8 u_dec_t (
    .en  (1'b1),
    .sel (sc),
    .y   (t)
  );

  exec_dec_3to8 u_dec_d (
    .en  (1'b1),
    .sel (bus_if.ir[14:12]),
    .y   (d)
  );

endmodule : cpu_exec_core

// File: tb/tb_cpu_exec_core.sv
// -----------------------------------------------------------------------------
// tb_cpu_exec_core
// Directed-vector bench for cpu_exec_core with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cpu_exec_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  sc;
  logic        ac_and, ac_add, ac_dr, ac_inpr, ac_cmp, ac_shr, ac_shl;
  logic        ac_inr, ac_clr, e_clr, e_cmp;
  logic [15:0] ac;
  logic        e;
  logic [15:0] ac_nxt;
  logic        e_nxt;
  logic [7:0]  t;
  logic [7:0]  d;

  int unsigned n_vec;
  int unsigned n_miss;

  logic [15:0] bus_exp [8];
  logic        inc_e_exp;

  cpu_exec_core_if bus_if ();

  cpu_exec_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus_if  (bus_if.slave),
    .sc      (sc),
    .ac_and  (ac_and),
    .ac_add  (ac_add),
    .ac_dr   (ac_dr),
    .ac_inpr (ac_inpr),
    .ac_cmp  (ac_cmp),
    .ac_shr  (ac_shr),
    .ac_shl  (ac_shl),
    .ac_inr  (ac_inr),
    .ac_clr  (ac_clr),
    .e_clr   (e_clr),
    .e_cmp   (e_cmp),
    .ac      (ac),
    .e       (e),
    .ac_nxt  (ac_nxt),
    .e_nxt   (e_nxt),
    .t       (t),
    .d       (d)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: count and report
  task automatic chk_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    ac_and = 1'b0; ac_add = 1'b0; ac_dr = 1'b0; ac_inpr = 1'b0;
    ac_cmp = 1'b0; ac_shr = 1'b0; ac_shl = 1'b0; ac_inr = 1'b0;
    ac_clr = 1'b0; e_clr = 1'b0; e_cmp = 1'b0;
  endtask

  // Load AC through DR; set_e: 0 clear E, 1 complement E, 2 leave E
  task automatic load_ac(input logic [15:0] v, input int set_e);
    bus_if.dr = v;
    ac_dr = 1'b1;
    e_clr = (set_e == 0);
    e_cmp = (set_e == 1);
    step();
    clr_strobes();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
`ifdef EXEC_INC_CARRY_EN
    inc_e_exp = 1'b1;
`else
    inc_e_exp = 1'b0;
`endif
    rst_n = 1'b0;
    en    = 1'b1;
    sc    = 3'd0;
    clr_strobes();
    bus_if.bus_ctl  = 3'd0;
    bus_if.ar       = 12'h000;
    bus_if.pc       = 12'h000;
    bus_if.dr       = 16'h0000;
    bus_if.ir       = 16'h0000;
    bus_if.mem_data = 16'h0000;
    bus_if.inpr     = 8'h00;

    // Reset state
    #3;
    chk_vec("rst_ac", ac, 16'h0000);
    chk_vec("rst_e", {15'd0, e}, 16'h0000);
    step();
    rst_n = 1'b1;
    step();

    // Async reset mid-cycle with AC = 1234, E = 1
    load_ac(16'h1234, 0);
    load_ac(16'h1234, 1);
    chk_vec("pre_rst_ac", ac, 16'h1234);
    chk_vec("pre_rst_e", {15'd0, e}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("async_rst_ac", ac, 16'h0000);
    chk_vec("async_rst_e", {15'd0, e}, 16'h0000);
    rst_n = 1'b1;
    step();

    // Bus sweep
    load_ac(16'h0F0F, 2);
    bus_if.ar       = 12'hABC;
    bus_if.pc       = 12'h123;
    bus_if.dr       = 16'h5A5A;
    bus_if.ir       = 16'h7001;
    bus_if.mem_data = 16'hBEEF;
    bus_exp = '{16'h0000, 16'h0ABC, 16'h0123, 16'h5A5A,
                16'h0F0F, 16'h7001, 16'h0000, 16'hBEEF};
    for (int i = 0; i < 8; i++) begin
      bus_if.bus_ctl = 3'(i);
      #1;
      chk_vec($sformatf("bus_sel%0d", i), bus_if.bus_data, bus_exp[i]);
    end

    // Add with carry
    load_ac(16'hFFFF, 0);
    bus_if.dr = 16'h0002;
    ac_add = 1'b1;
    #1;
    chk_vec("add_ac_nxt", ac_nxt, 16'h0001);
    chk_vec("add_e_nxt", {15'd0, e_nxt}, 16'h0001);
    step();
    clr_strobes();
    chk_vec("add_ac", ac, 16'h0001);
    chk_vec("add_e", {15'd0, e}, 16'h0001);
    bus_if.dr = 16'h00FF;
    ac_and = 1'b1;
    step();
    clr_strobes();
    chk_vec("and_ac", ac, 16'h0001);
    chk_vec("and_e_hold", {15'd0, e}, 16'h0001);

    // Rotate right then left through E
    load_ac(16'h8001, 0);
    ac_shr = 1'b1;
    step();
    clr_strobes();
    chk_vec("shr_ac", ac, 16'h4000);
    chk_vec("shr_e", {15'd0, e}, 16'h0001);
    ac_shl = 1'b1;
    step();
    clr_strobes();
    chk_vec("shl_ac", ac, 16'h8001);
    chk_vec("shl_e", {15'd0, e}, 16'h0000);

    // Increment wraps; E depends on build option
    load_ac(16'hFFFF, 0);
    ac_inr = 1'b1;
    step();
    clr_strobes();
    chk_vec("inr_ac", ac, 16'h0000);
    chk_vec("inr_e", {15'd0, e}, {15'd0, inc_e_exp});

    // Complement
    load_ac(16'h00F0, 2);
    ac_cmp = 1'b1;
    step();
    clr_strobes();
    chk_vec("cmp_ac", ac, 16'hFF0F);

    // Input character into low byte
    load_ac(16'hAB00, 2);
    bus_if.inpr = 8'h5C;
    ac_inpr = 1'b1;
    step();
    clr_strobes();
    chk_vec("inpr_ac", ac, 16'hAB5C);

    // Priorities: clear beats load, AND beats ADD
    ac_clr = 1'b1;
    ac_dr  = 1'b1;
    bus_if.dr = 16'h7777;
    step();
    clr_strobes();
    chk_vec("clr_over_ld", ac, 16'h0000);
    load_ac(16'h0F0F, 2);
    bus_if.dr = 16'h00FF;
    ac_and = 1'b1;
    ac_add = 1'b1;
    step();
    clr_strobes();
    chk_vec("and_over_add", ac, 16'h000F);

    // Timing decode
    for (int k = 0; k < 8; k++) begin
      sc = 3'(k);
      #1;
      chk_vec($sformatf("t_sc%0d", k), {8'h00, t}, 16'h0001 << k);
    end

    // Opcode decode
    bus_if.ir = 16'h7800;
    #1;
    chk_vec("d_op7", {8'h00, d}, 16'h0080);
    bus_if.ir = 16'h2ABC;
    #1;
    chk_vec("d_op2", {8'h00, d}, 16'h0004);

    // Freeze with en = 0
    load_ac(16'h3C3C, 0);
    en     = 1'b0;
    ac_clr = 1'b1;
    e_cmp  = 1'b1;
    step();
    clr_strobes();
    en = 1'b1;
    chk_vec("freeze_ac", ac, 16'h3C3C);
    chk_vec("freeze_e", {15'd0, e}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cpu_exec_core
